exc_timer_ctrl: RTL and testbench

EXC_TIMER_CTRL -- requirements
Module: exc_timer_ctrl

---
 rtl/exc_timer_ctrl.sv | 158 +++++++++++++++
 tb/tb_exc_timer_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_timer_ctrl.sv
// Timer CSRs (TCFG/TVAL) and WB-stage exception/ERTN commit sequencer.
// A trap or ERTN pulses once in TAKE, then holds a fetch redirect in REDIR until accepted.
module exc_timer_ctrl #(
   parameter logic [13:0] TCFG_NUM = 14'h041,
   parameter logic [13:0] TVAL_NUM = 14'h042
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        csr_we,
   input  logic [13:0] csr_num,
   input  logic [31:0] csr_wmask,
   input  logic [31:0] csr_wvalue,
   output logic [31:0] tcfg_rvalue,
   output logic [31:0] tval_rvalue,
   output logic [31:0] timer_cnt,
   input  logic [12:0] estat_is,
   input  logic [12:0] ecfg_lie,
   input  logic        crmd_ie,
   input  logic [31:0] eentry,
   input  logic [31:0] era,
   input  logic        wb_valid,
   input  logic [4:0]  wb_exc,
   input  logic        wb_ertn,
   input  logic [31:0] wb_pc_in,
   output logic        wb_ex,
   output logic [5:0]  wb_ecode,
   output logic [8:0]  wb_esubcode,
   output logic [31:0] wb_pc,
   output logic        ertn_flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, TAKE, REDIR} state_e;

   state_e      state_q, state_d;
   logic        tcfg_en_q, tcfg_en_d;
   logic        tcfg_per_q, tcfg_per_d;
   logic [29:0] tcfg_init_q, tcfg_init_d;
   logic [31:0] cnt_q, cnt_d;
   logic        is_ex_q, is_ex_d;
   logic [5:0]  ecode_q, ecode_d;
   logic [8:0]  esub_q, esub_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] rpc_q, rpc_d;

   logic        tcfg_we;
   logic [31:0] tcfg_new;
   logic        int_pending;
   logic        trap;
   logic [5:0]  trap_ecode;

   // TVAL is read-only; an address clash leaves TCFG unwritable rather than aliased onto TVAL.
   assign tcfg_we  = csr_we && (csr_num == TCFG_NUM) && (TCFG_NUM != TVAL_NUM);
   assign tcfg_new = (csr_wmask & csr_wvalue) | (~csr_wmask & tcfg_rvalue);

   always_comb begin
      tcfg_en_d   = tcfg_en_q;
      tcfg_per_d  = tcfg_per_q;
      tcfg_init_d = tcfg_init_q;
      cnt_d       = cnt_q;
      if (tcfg_we) begin
         tcfg_en_d   = tcfg_new[0];
         tcfg_per_d  = tcfg_new[1];
         tcfg_init_d = tcfg_new[31:2];
         cnt_d       = {tcfg_new[31:2], 2'b00};
      end else if (tcfg_en_q) begin
         if (cnt_q == 32'd0) begin
            cnt_d = tcfg_per_q ? {tcfg_init_q, 2'b00} : 32'hFFFF_FFFF;
         end else if (cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q - 32'd1;
         end
      end
   end

   assign int_pending = crmd_ie & (|(estat_is & ecfg_lie));
   assign trap        = int_pending | (|wb_exc);

   // wb_exc is {ALE,BRK,SYS,INE,ADEF}; interrupts outrank every synchronous exception.
   always_comb begin
      trap_ecode = 6'h00;
      if (int_pending)    trap_ecode = 6'h00;
      else if (wb_exc[0]) trap_ecode = 6'h08;
      else if (wb_exc[1]) trap_ecode = 6'h0D;
      else if (wb_exc[2]) trap_ecode = 6'h0B;
      else if (wb_exc[3]) trap_ecode = 6'h0C;
      else if (wb_exc[4]) trap_ecode = 6'h09;
   end

   always_comb begin
      state_d = state_q;
      is_ex_d = is_ex_q;
      ecode_d = ecode_q;
      esub_d  = esub_q;
      pc_d    = pc_q;
      rpc_d   = rpc_q;
      unique case (state_q)
         IDLE: begin
            if (wb_valid && trap) begin
               is_ex_d = 1'b1;
               ecode_d = trap_ecode;
               esub_d  = 9'd0;
               pc_d    = wb_pc_in;
               rpc_d   = eentry;
               state_d = TAKE;
            end else if (wb_valid && wb_ertn) begin
               is_ex_d = 1'b0;
               rpc_d   = era;
               state_d = TAKE;
            end
         end
         TAKE:  state_d = REDIR;
         REDIR: if (redirect_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q     <= IDLE;
         tcfg_en_q   <= 1'b0;
         tcfg_per_q  <= 1'b0;
         tcfg_init_q <= 30'd0;
         cnt_q       <= 32'hFFFF_FFFF;
         is_ex_q     <= 1'b0;
         ecode_q     <= 6'd0;
         esub_q      <= 9'd0;
         pc_q        <= 32'd0;
         rpc_q       <= 32'd0;
      end else begin
         state_q     <= state_d;
         tcfg_en_q   <= tcfg_en_d;
         tcfg_per_q  <= tcfg_per_d;
         tcfg_init_q <= tcfg_init_d;
         cnt_q       <= cnt_d;
         is_ex_q     <= is_ex_d;
         ecode_q     <= ecode_d;
         esub_q      <= esub_d;
         pc_q        <= pc_d;
         rpc_q       <= rpc_d;
      end
   end

   assign tcfg_rvalue    = {tcfg_init_q, tcfg_per_q, tcfg_en_q};
   assign timer_cnt      = cnt_q;
   assign tval_rvalue    = cnt_q;
   assign wb_ex          = (state_q == TAKE) && is_ex_q;
   assign ertn_flush     = (state_q == TAKE) && !is_ex_q;
   assign redirect_valid = (state_q == REDIR);
   assign redirect_pc    = rpc_q;
   assign busy           = (state_q != IDLE);
   assign wb_ecode       = ecode_q;
   assign wb_esubcode    = esub_q;
   assign wb_pc          = pc_q;

endmodule

// File: tb/tb_exc_timer_ctrl.sv
// Bench for exc_timer_ctrl: timer vector table, trap table, and hand-written
// sequences for redirect back-pressure, ERTN and mid-sequence reset.
module tb_exc_timer_ctrl;

   logic        clock = 1'b0;
   logic        resetn;
   logic        csr_we;
   logic [13:0] csr_num;
   logic [31:0] csr_wmask, csr_wvalue;
   logic [31:0] tcfg_rvalue, tval_rvalue, timer_cnt;
   logic [12:0] estat_is, ecfg_lie;
   logic        crmd_ie;
   logic [31:0] eentry, era;
   logic        wb_valid;
   logic [4:0]  wb_exc;
   logic        wb_ertn;
   logic [31:0] wb_pc_in;
   logic        wb_ex;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_pc;
   logic        ertn_flush, redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready, busy;

   always #5 clock = ~clock;

   exc_timer_ctrl dut (
      .clock(clock), .resetn(resetn),
      .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
      .tcfg_rvalue(tcfg_rvalue), .tval_rvalue(tval_rvalue), .timer_cnt(timer_cnt),
      .estat_is(estat_is), .ecfg_lie(ecfg_lie), .crmd_ie(crmd_ie),
      .eentry(eentry), .era(era),
      .wb_valid(wb_valid), .wb_exc(wb_exc), .wb_ertn(wb_ertn), .wb_pc_in(wb_pc_in),
      .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
      .ertn_flush(ertn_flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready), .busy(busy)
   );

   typedef enum int {S_CNT, S_TCFG, S_TVAL, S_WBEX, S_ERTN, S_RV, S_RPC, S_BUSY,
                     S_ECODE, S_ESUB, S_PC} sig_e;
   typedef struct {sig_e sel; logic [31:0] exp; string name;} exp_t;
   typedef struct {logic we; logic [13:0] num; logic [31:0] mask, val, exp_cnt, exp_tcfg;} tvec_t;
   typedef struct {logic [4:0] exc; logic [12:0] is, lie; logic ie, ertn; logic [5:0] ecode;} xvec_t;

   localparam logic [31:0] EENTRY = 32'h1C00_8000;
   localparam logic [31:0] ERA    = 32'h1C00_0100;

   exp_t  sb_q[$];
   tvec_t tv[$];
   xvec_t xv[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   function automatic logic [31:0] probe(sig_e s);
      case (s)
         S_CNT:   return timer_cnt;
         S_TCFG:  return tcfg_rvalue;
         S_TVAL:  return tval_rvalue;
         S_WBEX:  return {31'd0, wb_ex};
         S_ERTN:  return {31'd0, ertn_flush};
         S_RV:    return {31'd0, redirect_valid};
         S_RPC:   return redirect_pc;
         S_BUSY:  return {31'd0, busy};
         S_ECODE: return {26'd0, wb_ecode};
         S_ESUB:  return {23'd0, wb_esubcode};
         S_PC:    return wb_pc;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic expect_val(sig_e s, logic [31:0] v, string name);
      exp_t e;
      e.sel = s; e.exp = v; e.name = name;
      sb_q.push_back(e);
   endtask

   // Advance one clock, then retire every pending expectation against the DUT.
   task automatic tick_check();
      exp_t e;
      logic [31:0] act;
      @(posedge clock);
      #1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         act = probe(e.sel);
         n_checks++;
         if (act === e.exp) n_pass++;
         else $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
      end
   endtask

   task automatic add_tv(logic we, logic [13:0] num, logic [31:0] mask, logic [31:0] val,
                         logic [31:0] ec, logic [31:0] et);
      tvec_t t;
      t.we = we; t.num = num; t.mask = mask; t.val = val; t.exp_cnt = ec; t.exp_tcfg = et;
      tv.push_back(t);
   endtask

   task automatic add_xv(logic [4:0] exc, logic [12:0] is, logic [12:0] lie, logic ie,
                         logic ertn, logic [5:0] ecode);
      xvec_t x;
      x.exc = exc; x.is = is; x.lie = lie; x.ie = ie; x.ertn = ertn; x.ecode = ecode;
      xv.push_back(x);
   endtask

   task automatic clear_wb();
      wb_valid = 1'b0; wb_exc = 5'd0; wb_ertn = 1'b0;
      estat_is = 13'd0; ecfg_lie = 13'd0; crmd_ie = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn = 1'b0; csr_we = 1'b0; csr_num = 14'd0; csr_wmask = 32'd0; csr_wvalue = 32'd0;
      eentry = EENTRY; era = ERA; wb_pc_in = 32'd0; redirect_ready = 1'b0;
      clear_wb();

      // Timer vectors: periodic countdown, one-shot wrap/hold, masked write, TVAL write, write-vs-tick.
      add_tv(1, 14'h041, 32'hFFFF_FFFF, 32'h0000_000B, 32'd8, 32'h0B);
      for (int i = 7; i >= 0; i--) add_tv(0, 14'h041, 32'd0, 32'd0, i, 32'h0B);
      add_tv(0, 14'h041, 32'd0, 32'd0, 32'd8, 32'h0B);
      add_tv(0, 14'h041, 32'd0, 32'd0, 32'd7, 32'h0B);
      add_tv(1, 14'h041, 32'hFFFF_FFFF, 32'h0000_0009, 32'd8, 32'h09);
      for (int i = 7; i >= 0; i--) add_tv(0, 14'h041, 32'd0, 32'd0, i, 32'h09);
      for (int i = 0; i < 3; i++) add_tv(0, 14'h041, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h09);
      add_tv(1, 14'h041, 32'h0000_0001, 32'h0000_0000, 32'd8, 32'h08);
      add_tv(0, 14'h041, 32'd0, 32'd0, 32'd8, 32'h08);
      add_tv(1, 14'h042, 32'hFFFF_FFFF, 32'h0000_0005, 32'd8, 32'h08);
      add_tv(1, 14'h041, 32'hFFFF_FFFF, 32'h0000_0013, 32'd16, 32'h13);
      add_tv(0, 14'h041, 32'd0, 32'd0, 32'd15, 32'h13);
      add_tv(1, 14'h041, 32'hFFFF_FFFC, 32'h0000_000C, 32'd12, 32'h0F);
      add_tv(0, 14'h041, 32'd0, 32'd0, 32'd11, 32'h0F);
      add_tv(1, 14'h041, 32'hFFFF_FFFF, 32'h0000_0000, 32'd0, 32'h00);
      add_tv(0, 14'h041, 32'd0, 32'd0, 32'd0, 32'h00);

      // Trap vectors: gating, priority, and trap winning over ERTN.
      add_xv(5'b00001, 13'h0800, 13'h0800, 1'b0, 1'b0, 6'h08);
      add_xv(5'b00001, 13'h0800, 13'h0800, 1'b1, 1'b0, 6'h00);
      add_xv(5'b01100, 13'h0000, 13'h0000, 1'b0, 1'b0, 6'h0B);
      add_xv(5'b11000, 13'h0000, 13'h0000, 1'b0, 1'b0, 6'h0C);
      add_xv(5'b10000, 13'h0000, 13'h0000, 1'b0, 1'b1, 6'h09);
      add_xv(5'b00000, 13'h1FFF, 13'h0001, 1'b1, 1'b0, 6'h00);

      // Reset state
      expect_val(S_CNT, 32'hFFFF_FFFF, "rst_cnt");
      expect_val(S_TCFG, 32'd0, "rst_tcfg");
      expect_val(S_WBEX, 32'd0, "rst_wbex");
      expect_val(S_ERTN, 32'd0, "rst_ertn");
      expect_val(S_RV, 32'd0, "rst_rv");
      expect_val(S_BUSY, 32'd0, "rst_busy");
      expect_val(S_ECODE, 32'd0, "rst_ecode");
      expect_val(S_ESUB, 32'd0, "rst_esub");
      expect_val(S_PC, 32'd0, "rst_pc");
      expect_val(S_RPC, 32'd0, "rst_rpc");
      tick_check();
      resetn = 1'b1;

      foreach (tv[i]) begin
         csr_we = tv[i].we; csr_num = tv[i].num;
         csr_wmask = tv[i].mask; csr_wvalue = tv[i].val;
         expect_val(S_CNT, tv[i].exp_cnt, $sformatf("timer_cnt[%0d]", i));
         expect_val(S_TVAL, tv[i].exp_cnt, $sformatf("tval[%0d]", i));
         expect_val(S_TCFG, tv[i].exp_tcfg, $sformatf("tcfg[%0d]", i));
         tick_check();
      end
      csr_we = 1'b0;

      foreach (xv[i]) begin
         wb_valid = 1'b1; wb_exc = xv[i].exc; wb_ertn = xv[i].ertn;
         estat_is = xv[i].is; ecfg_lie = xv[i].lie; crmd_ie = xv[i].ie;
         wb_pc_in = 32'h1C00_0000 + 32'(i) * 32'h10;
         expect_val(S_WBEX, 32'd1, $sformatf("x%0d_wbex", i));
         expect_val(S_ERTN, 32'd0, $sformatf("x%0d_ertn", i));
         expect_val(S_ECODE, {26'd0, xv[i].ecode}, $sformatf("x%0d_ecode", i));
         expect_val(S_ESUB, 32'd0, $sformatf("x%0d_esub", i));
         expect_val(S_PC, wb_pc_in, $sformatf("x%0d_pc", i));
         expect_val(S_BUSY, 32'd1, $sformatf("x%0d_busy", i));
         tick_check();
         clear_wb();
         redirect_ready = 1'b1;
         expect_val(S_WBEX, 32'd0, $sformatf("x%0d_wbex_off", i));
         expect_val(S_RV, 32'd1, $sformatf("x%0d_rv", i));
         expect_val(S_RPC, EENTRY, $sformatf("x%0d_rpc", i));
         tick_check();
         expect_val(S_RV, 32'd0, $sformatf("x%0d_rv_off", i));
         expect_val(S_BUSY, 32'd0, $sformatf("x%0d_idle", i));
         expect_val(S_ECODE, {26'd0, xv[i].ecode}, $sformatf("x%0d_ecode_hold", i));
         tick_check();
         redirect_ready = 1'b0;
      end

      // INE over SYS, redirect back-pressure, and new events ignored while busy
      wb_valid = 1'b1; wb_exc = 5'b00110; wb_pc_in = 32'h1C00_0040;
      expect_val(S_WBEX, 32'd1, "ine_wbex");
      expect_val(S_ECODE, 32'h0D, "ine_ecode");
      expect_val(S_PC, 32'h1C00_0040, "ine_pc");
      tick_check();
      wb_exc = 5'b00001; wb_ertn = 1'b1; wb_pc_in = 32'h1C00_00F0;
      crmd_ie = 1'b1; estat_is = 13'h0800; ecfg_lie = 13'h0800;
      expect_val(S_WBEX, 32'd0, "ine_wbex_once");
      expect_val(S_ERTN, 32'd0, "ine_no_ertn");
      expect_val(S_RV, 32'd1, "ine_rv");
      expect_val(S_RPC, EENTRY, "ine_rpc");
      tick_check();
      for (int k = 0; k < 3; k++) begin
         expect_val(S_RV, 32'd1, $sformatf("ine_rv_hold%0d", k));
         expect_val(S_RPC, EENTRY, $sformatf("ine_rpc_hold%0d", k));
         expect_val(S_ECODE, 32'h0D, $sformatf("ine_ecode_hold%0d", k));
         expect_val(S_PC, 32'h1C00_0040, $sformatf("ine_pc_hold%0d", k));
         tick_check();
      end
      clear_wb();
      redirect_ready = 1'b1;
      expect_val(S_RV, 32'd0, "ine_rv_done");
      expect_val(S_BUSY, 32'd0, "ine_idle");
      tick_check();
      redirect_ready = 1'b0;

      // ERTN, with a second ERTN presented while busy
      wb_valid = 1'b1; wb_ertn = 1'b1; era = ERA;
      expect_val(S_ERTN, 32'd1, "ertn_pulse");
      expect_val(S_WBEX, 32'd0, "ertn_no_ex");
      expect_val(S_BUSY, 32'd1, "ertn_busy");
      expect_val(S_ECODE, 32'h0D, "ertn_ecode_hold");
      expect_val(S_PC, 32'h1C00_0040, "ertn_pc_hold");
      tick_check();
      expect_val(S_ERTN, 32'd0, "ertn_once");
      expect_val(S_RV, 32'd1, "ertn_rv");
      expect_val(S_RPC, ERA, "ertn_rpc");
      tick_check();
      redirect_ready = 1'b1;
      expect_val(S_ERTN, 32'd0, "ertn_second_ignored");
      expect_val(S_BUSY, 32'd0, "ertn_idle");
      tick_check();
      clear_wb();
      redirect_ready = 1'b0;
      expect_val(S_BUSY, 32'd0, "ertn_stays_idle");
      tick_check();

      // Reset during TAKE
      wb_valid = 1'b1; wb_exc = 5'b10000; wb_pc_in = 32'h1C00_0200;
      expect_val(S_WBEX, 32'd1, "rtake_wbex");
      expect_val(S_ECODE, 32'h09, "rtake_ecode");
      tick_check();
      clear_wb();
      resetn = 1'b0;
      expect_val(S_WBEX, 32'd0, "rtake_wbex_off");
      expect_val(S_BUSY, 32'd0, "rtake_busy");
      expect_val(S_ECODE, 32'd0, "rtake_ecode_clr");
      tick_check();
      resetn = 1'b1;
      expect_val(S_RV, 32'd0, "rtake_no_rv");
      expect_val(S_WBEX, 32'd0, "rtake_no_wbex");
      tick_check();

      // Reset during REDIR
      wb_valid = 1'b1; wb_exc = 5'b00100; wb_pc_in = 32'h1C00_0300;
      expect_val(S_WBEX, 32'd1, "rredir_wbex");
      tick_check();
      clear_wb();
      expect_val(S_RV, 32'd1, "rredir_rv");
      tick_check();
      resetn = 1'b0;
      expect_val(S_RV, 32'd0, "rredir_rv_off");
      expect_val(S_BUSY, 32'd0, "rredir_busy");
      expect_val(S_CNT, 32'hFFFF_FFFF, "rredir_cnt");
      expect_val(S_RPC, 32'd0, "rredir_rpc");
      expect_val(S_PC, 32'd0, "rredir_pc");
      tick_check();
      resetn = 1'b1;
      expect_val(S_RV, 32'd0, "rredir_no_rv");
      expect_val(S_WBEX, 32'd0, "rredir_no_wbex");
      expect_val(S_BUSY, 32'd0, "rredir_idle");
      tick_check();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
